hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage RV32I core.
- Sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
  - load-use hazards, handled with a one-bubble stall;
  - taken-branch/jump redirect, handled by flushing D and E;
  - multi-cycle data-memory access in M, handled by freezing F..M and bubbling W.
- Contains a 2-state memory-wait FSM, a watchdog counter and saturating performance counters.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use bubbles,
// branch-redirect flushes and data-memory wait freezes, plus a watchdog and counters.
module hazard_ctrl #(
  parameter int RFIDX_W     = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RFIDX_W-1:0] rs1D,
  input  logic [RFIDX_W-1:0] rs2D,
  input  logic               useRs1D,
  input  logic               useRs2D,
  input  logic [RFIDX_W-1:0] rdE,
  input  logic               memReadE,
  input  logic               branchTakenE,
  input  logic               memReqM,
  input  logic               memAckM,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flushD,
  output logic               flushE,
  output logic               flushW,
  output logic               memTimeout,
  output logic [CNT_W-1:0]   stallCnt,
  output logic [CNT_W-1:0]   flushCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memStall;
  logic              loadUse;

  // Hazard detection: x0 is never a producer, so rdE==0 never stalls.
  always_comb begin
    memStall = memReqM & ~memAckM;
    loadUse  = memReadE & (rdE != {RFIDX_W{1'b0}}) &
               ((useRs1D & (rdE == rs1D)) | (useRs2D & (rdE == rs2D)));
  end

  // Prioritised stall/flush decode; the release cycle of a wait is kept quiet
  // so that a frozen E instruction re-presents on the following cycle.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (rst) begin
      stallF = 1'b0;
    end else if (memStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (state == MEMWAIT) begin
      stallF = 1'b0;
    end else if (branchTakenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (loadUse) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else begin
      stallF = 1'b0;
    end
  end

  // Memory-wait FSM and watchdog; the flag rises as the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      waitCnt    <= {WAIT_W{1'b0}};
      memTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state   <= MEMWAIT;
            waitCnt <= WAIT_ONE;
          end else begin
            waitCnt <= {WAIT_W{1'b0}};
          end
        end
        MEMWAIT: begin
          if (memStall) begin
            if (waitCnt < WAIT_MAX) begin
              waitCnt <= waitCnt + WAIT_ONE;
            end else begin
              waitCnt <= WAIT_MAX;
            end
            if (waitCnt >= WAIT_LAST) begin
              memTimeout <= 1'b1;
            end else begin
              memTimeout <= memTimeout;
            end
          end else begin
            state   <= RUN;
            waitCnt <= {WAIT_W{1'b0}};
          end
        end
        default: begin
          state   <= RUN;
          waitCnt <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= {CNT_W{1'b0}};
      flushCnt <= {CNT_W{1'b0}};
    end else begin
      if (stallF && (stallCnt != CNT_MAX)) begin
        stallCnt <= stallCnt + CNT_ONE;
      end else begin
        stallCnt <= stallCnt;
      end
      if (flushD && (flushCnt != CNT_MAX)) begin
        flushCnt <= flushCnt + CNT_ONE;
      end else begin
        flushCnt <= flushCnt;
      end
    end
  end

endmodule
